// File: rtl/instr_dispatcher_pkg.sv
// Shared definitions for the instruction dispatcher and the processor array.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package instr_dispatcher_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT,
        ST_GAP,
        ST_FINISH,
        ST_ERROR
    } state_t;

    // Bubble word placed on the bus between issues so every issue looks new
    localparam logic [15:0] NOP_INST = 16'hFFFF;

    // Field slices of the 16-bit instruction word
    localparam int PROC_MSB   = 15;
    localparam int PROC_LSB   = 14;
    localparam int OPCODE_MSB = 13;
    localparam int OPCODE_LSB = 12;
    localparam int TAG_MSB    = 11;
    localparam int TAG_LSB    = 8;
    localparam int DATA_MSB   = 7;
    localparam int DATA_LSB   = 0;

    typedef struct packed {
        logic [1:0] proc;
        logic [1:0] opcode;
        logic [3:0] tag;
        logic [7:0] data;
    } inst_t;

    // Opcodes understood by the processor modules
    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_EVICT = 2'b10;
    localparam logic [1:0] OP_NOP   = 2'b11;

    // Processor IDs
    localparam logic [1:0] P0 = 2'b00;
    localparam logic [1:0] P1 = 2'b01;
    localparam logic [1:0] P2 = 2'b10;

    function automatic inst_t to_inst(input logic [15:0] w);
        return inst_t'(w);
    endfunction

endpackage

// File: rtl/instr_mem.sv
// Program store: DEPTH x 16 single-port RAM, synchronous write, registered read.
// Latency: read data valid one cycle after re; write lands on the same edge.
// Backpressure: none; write has priority over read, rdata holds when idle.
//
// Ports: clock; we/re strobes; addr shared by read and write; wdata in; rdata out.
module instr_mem #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clock,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [15:0]       wdata,
    output logic [15:0]       rdata
);

    logic [15:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[addr] <= wdata;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/instr_dispatcher.sv
// Broadcasts a loaded program one instruction at a time, waits for all processors to finish each.
// Latency: start -> FETCH next cycle, instruction on the bus one cycle later; FFFF bubble between issues.
// Backpressure: each issue is held until every done flag is set (after a stale first cycle); watchdog on TIMEOUT.
//
// Ports: clock/reset (sync, active-high); load_en/load_addr/load_data program write; prog_len/start run
// request; done_vec per-processor done; proc/opcode/tag/data instruction bus with inst_valid/inst_idx;
// busy/finished/error status.
module instr_dispatcher
    import instr_dispatcher_pkg::*;
#(
    parameter int NUM_PROC   = 3,
    parameter int DEPTH      = 16,
    parameter int ADDR_W     = 4,
    parameter int GAP_CYCLES = 1,
    parameter int TIMEOUT    = 64
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                load_en,
    input  logic [ADDR_W-1:0]   load_addr,
    input  logic [15:0]         load_data,
    input  logic [ADDR_W:0]     prog_len,
    input  logic                start,
    input  logic [NUM_PROC-1:0] done_vec,
    output logic [1:0]          proc,
    output logic [1:0]          opcode,
    output logic [3:0]          tag,
    output logic [7:0]          data,
    output logic                inst_valid,
    output logic [ADDR_W-1:0]   inst_idx,
    output logic                busy,
    output logic                finished,
    output logic                error
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  WAIT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYCLES - 1);
    localparam logic [ADDR_W:0]   LEN_MAX   = (ADDR_W + 1)'(DEPTH);

    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W:0]   len;
    logic [CNT_W-1:0]  wait_cnt;
    logic [GAP_W-1:0]  gap_cnt;

    logic              load_ok;
    logic              mem_we;
    logic              mem_re;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_rdata;
    logic [ADDR_W:0]   len_clamped;
    logic              last_inst;
    inst_t             cur;

    // The program may only change while no run is in flight
    assign load_ok  = (state == ST_IDLE) || (state == ST_FINISH) || (state == ST_ERROR);
    assign mem_we   = load_en && load_ok;
    assign mem_re   = (state == ST_FETCH);
    // Write and read never coincide (loads only outside FETCH), so one address port suffices
    assign mem_addr = mem_we ? load_addr : pc;

    assign len_clamped = (prog_len > LEN_MAX) ? LEN_MAX : prog_len;
    assign last_inst   = ({1'b0, pc} == (len - (ADDR_W + 1)'(1)));

    instr_mem #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clock (clock),
        .we    (mem_we),
        .re    (mem_re),
        .addr  (mem_addr),
        .wdata (load_data),
        .rdata (mem_rdata)
    );

    // The RAM's read register is the instruction register: it is loaded in FETCH and
    // held for the whole WAIT, so the bus is a clean mux of registers.
    assign cur      = inst_valid ? to_inst(mem_rdata) : to_inst(NOP_INST);
    assign proc     = cur.proc;
    assign opcode   = cur.opcode;
    assign tag      = cur.tag;
    assign data     = cur.data;
    assign inst_idx = pc;

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= ST_IDLE;
            pc         <= '0;
            len        <= '0;
            wait_cnt   <= '0;
            gap_cnt    <= '0;
            inst_valid <= 1'b0;
            busy       <= 1'b0;
            finished   <= 1'b0;
            error      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_FINISH: begin
                    if (start) begin
                        pc  <= '0;
                        len <= len_clamped;
                        if (len_clamped == '0) begin
                            state    <= ST_FINISH;
                            finished <= 1'b1;
                            busy     <= 1'b0;
                        end else begin
                            state    <= ST_FETCH;
                            finished <= 1'b0;
                            busy     <= 1'b1;
                        end
                    end
                end
                ST_FETCH: begin
                    state      <= ST_WAIT;
                    inst_valid <= 1'b1;
                    wait_cnt   <= '0;
                end
                ST_WAIT: begin
                    // done_vec still reflects the previous instruction on the first WAIT cycle
                    if ((wait_cnt != '0) && (&done_vec)) begin
                        state      <= ST_GAP;
                        inst_valid <= 1'b0;
                        gap_cnt    <= '0;
                    end else if (wait_cnt == WAIT_LAST) begin
                        state      <= ST_ERROR;
                        inst_valid <= 1'b0;
                        busy       <= 1'b0;
                        error      <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        if (last_inst) begin
                            state    <= ST_FINISH;
                            busy     <= 1'b0;
                            finished <= 1'b1;
                        end else begin
                            pc    <= pc + ADDR_W'(1);
                            state <= ST_FETCH;
                        end
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end
                ST_ERROR: begin
                    // Sticky until reset
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_dispatcher.sv
// Directed + randomized bench for instr_dispatcher with a transaction-level expectation model.
// Inputs are driven 1 time unit after posedge; outputs are sampled at the same point.
// Summary line reports passed/total checks.
module tb_instr_dispatcher;

    localparam int NUM_PROC   = 3;
    localparam int DEPTH      = 16;
    localparam int ADDR_W     = 4;
    localparam int GAP_CYCLES = 1;
    localparam int TIMEOUT    = 64;
    localparam logic [15:0] NOP = 16'hFFFF;

    localparam int M_RAND  = 0;  // random done flags, random stray starts
    localparam int M_HOLD  = 1;  // done held at all-ones throughout
    localparam int M_NEVER = 2;  // one processor never done
    localparam int M_LATE  = 3;  // all-ones from the second WAIT cycle on

    logic                clock;
    logic                reset;
    logic                load_en;
    logic [ADDR_W-1:0]   load_addr;
    logic [15:0]         load_data;
    logic [ADDR_W:0]     prog_len;
    logic                start;
    logic [NUM_PROC-1:0] done_vec;
    logic [1:0]          proc;
    logic [1:0]          opcode;
    logic [3:0]          tag;
    logic [7:0]          data;
    logic                inst_valid;
    logic [ADDR_W-1:0]   inst_idx;
    logic                busy;
    logic                finished;
    logic                error;

    int passed = 0;
    int total  = 0;
    logic [15:0] model_mem [DEPTH];

    instr_dispatcher #(
        .NUM_PROC   (NUM_PROC),
        .DEPTH      (DEPTH),
        .ADDR_W     (ADDR_W),
        .GAP_CYCLES (GAP_CYCLES),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .load_en    (load_en),
        .load_addr  (load_addr),
        .load_data  (load_data),
        .prog_len   (prog_len),
        .start      (start),
        .done_vec   (done_vec),
        .proc       (proc),
        .opcode     (opcode),
        .tag        (tag),
        .data       (data),
        .inst_valid (inst_valid),
        .inst_idx   (inst_idx),
        .busy       (busy),
        .finished   (finished),
        .error      (error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    endtask

    task automatic expect_out(input string name, input logic vld, input logic [15:0] word,
                              input logic bsy, input logic fin, input logic err);
        check({name, ".word"},     32'({proc, opcode, tag, data}), 32'(word));
        check({name, ".valid"},    32'(inst_valid), 32'(vld));
        check({name, ".busy"},     32'(busy), 32'(bsy));
        check({name, ".finished"}, 32'(finished), 32'(fin));
        check({name, ".error"},    32'(error), 32'(err));
    endtask

    task automatic expect_reset_values(input string name);
        expect_out(name, 1'b0, NOP, 1'b0, 1'b0, 1'b0);
        check({name, ".idx"}, 32'(inst_idx), 32'd0);
    endtask

    function automatic logic [NUM_PROC-1:0] pick_done(input int mode, input int c);
        case (mode)
            M_HOLD:  return '1;
            M_NEVER: return 3'b011;
            M_LATE:  return (c >= 1) ? '1 : '0;
            default: return ($urandom_range(0, 1) == 1) ? '1 : NUM_PROC'($urandom_range(0, 7));
        endcase
    endfunction

    // Only called when the dispatcher is idle, finished or in error
    task automatic load_word(input int addr, input logic [15:0] word);
        load_en   = 1'b1;
        load_addr = ADDR_W'(addr);
        load_data = word;
        tick();
        load_en = 1'b0;
        model_mem[addr] = word;
    endtask

    // Runs a program of len_in words; the expected sequence follows the issue rules:
    // one FETCH bubble, each word held until a non-first cycle sees all done,
    // GAP_CYCLES bubbles, then finish. Optional reset abort and illegal load mid-run.
    task automatic run_prog(input int len_in, input int mode, input int abort_idx,
                            input bit load_in_wait, output bit ended_err);
        int n;
        int c;
        bit leave;
        logic [NUM_PROC-1:0] dv;
        ended_err = 1'b0;
        n = (len_in > DEPTH) ? DEPTH : len_in;
        prog_len = (ADDR_W + 1)'(len_in);
        start = 1'b1;
        tick();
        start   = 1'b0;
        load_en = 1'b0;
        if (n == 0) begin
            expect_out("len0", 1'b0, NOP, 1'b0, 1'b1, 1'b0);
            return;
        end
        for (int i = 0; i < n; i++) begin
            expect_out("fetch", 1'b0, NOP, 1'b1, 1'b0, 1'b0);
            done_vec = pick_done(mode, -1);
            tick();
            c = 0;
            leave = 1'b0;
            while (!leave) begin
                expect_out("wait", 1'b1, model_mem[i], 1'b1, 1'b0, 1'b0);
                check("wait.idx", 32'(inst_idx), 32'(i));
                if (abort_idx == i && c == 1) begin
                    reset = 1'b1;
                    tick();
                    expect_reset_values("abort");
                    reset = 1'b0;
                    return;
                end
                if (load_in_wait && i == 0 && c == 0) begin
                    load_en   = 1'b1;
                    load_addr = '0;
                    load_data = ~model_mem[0];
                end else begin
                    load_en = 1'b0;
                end
                dv = pick_done(mode, c);
                done_vec = dv;
                if (mode == M_RAND) start = ($urandom_range(0, 3) == 0);
                tick();
                if (c >= 1 && dv == '1) begin
                    leave = 1'b1;
                    if (mode == M_HOLD || mode == M_LATE) check("hold_len", 32'(c + 1), 32'd2);
                end else if (c == TIMEOUT - 1) begin
                    start   = 1'b0;
                    load_en = 1'b0;
                    expect_out("timeout", 1'b0, NOP, 1'b0, 1'b0, 1'b1);
                    ended_err = 1'b1;
                    return;
                end else begin
                    c++;
                end
            end
            load_en = 1'b0;
            for (int g = 0; g < GAP_CYCLES; g++) begin
                expect_out("gap", 1'b0, NOP, 1'b1, 1'b0, 1'b0);
                done_vec = pick_done(mode, -1);
                if (mode == M_RAND) start = ($urandom_range(0, 3) == 0);
                tick();
            end
            start = 1'b0;
        end
        expect_out("finish", 1'b0, NOP, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        bit err_end;
        logic [15:0] w;

        reset     = 1'b1;
        load_en   = 1'b0;
        load_addr = '0;
        load_data = '0;
        prog_len  = '0;
        start     = 1'b0;
        done_vec  = '0;
        tick();
        tick();
        expect_reset_values("reset");
        reset = 1'b0;
        tick();
        expect_reset_values("idle");

        // Basic two-word program, done two cycles after issue
        load_word(0, {2'b01, 2'b00, 4'h3, 8'h00});
        load_word(1, {2'b10, 2'b01, 4'h5, 8'hAA});
        run_prog(2, M_LATE, -1, 1'b0, err_end);

        // Identical consecutive words with done held high throughout
        w = 16'($urandom);
        load_word(0, w);
        load_word(1, w);
        run_prog(2, M_HOLD, -1, 1'b0, err_end);
        done_vec = '0;

        // Empty program from FINISH
        run_prog(0, M_LATE, -1, 1'b0, err_end);

        // Randomized programs, including FFFF as a real word and lengths beyond DEPTH
        for (int r = 0; r < 4; r++) begin
            for (int a = 0; a < DEPTH; a++) load_word(a, (a == 3) ? NOP : 16'($urandom));
            run_prog((r == 0) ? 31 : $urandom_range(1, 31), M_RAND, -1, 1'b0, err_end);
        end

        // Reset during WAIT of instruction 1 of 3, then reissue from word 0
        for (int a = 0; a < 3; a++) load_word(a, 16'($urandom));
        run_prog(3, M_LATE, 1, 1'b0, err_end);
        tick();
        expect_reset_values("post_abort");
        run_prog(3, M_RAND, -1, 1'b0, err_end);

        // Load during WAIT is dropped; rerun shows the original word
        run_prog(2, M_LATE, -1, 1'b1, err_end);
        run_prog(2, M_LATE, -1, 1'b0, err_end);

        // Load together with start: the new word is the one issued
        load_en   = 1'b1;
        load_addr = '0;
        load_data = 16'h5A3C;
        model_mem[0] = 16'h5A3C;
        run_prog(1, M_LATE, -1, 1'b0, err_end);

        // Watchdog: one processor never reports done
        run_prog(2, M_NEVER, -1, 1'b0, err_end);
        check("timeout_seen", 32'(err_end), 32'd1);
        prog_len = 5'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        expect_out("err_sticky", 1'b0, NOP, 1'b0, 1'b0, 1'b1);
        done_vec = '0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        expect_reset_values("err_reset");

        // Empty program straight from IDLE
        run_prog(0, M_LATE, -1, 1'b0, err_end);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
